// File: rtl/key_debouncer.sv
// key_debouncer: conditions raw active-low pushbuttons into a clean pressed
// level with one-cycle press / release pulses and optional auto-repeat pulses.
// Each key channel is fully independent: synchroniser, debounce counter and
// repeat state machine are replicated per key.

module key_debouncer #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  // Debounce counter sizing; DB_LAST is the count seen on the edge where the
  // next increment would reach DEBOUNCE_CYCLES, i.e. the acceptance edge.
  localparam int             DCW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  // Repeat counter must hold the larger of the two repeat intervals.
  localparam int             RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int             RCW       = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;
  localparam logic [RCW-1:0] RD_VAL    = RCW'(REPEAT_DELAY);
  localparam logic [RCW-1:0] RP_VAL    = RCW'(REPEAT_PERIOD);
  localparam bit             REPEAT_EN = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rpt_state_e;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            sample;
    logic [DCW-1:0]  db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            repeat_q, repeat_d;
    logic            rise, fall;
    rpt_state_e      state_q, state_d;
    logic [RCW-1:0]  rpt_cnt_q, rpt_cnt_d;

    // Synchroniser chain, debounce counter and edge detection for this key.
    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
      sync1_d   = key_n[i];
      sync2_d   = sync1_q;
      sample    = ~sync2_q;
      level_d   = level_q;
      db_cnt_d  = '0;
      if (sample != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d = ~level_q;
        end else begin
          db_cnt_d = db_cnt_q + DCW'(1);
        end
      end
      rise      = level_d & ~level_q;
      fall      = ~level_d & level_q;
      press_d   = rise;
      release_d = fall;
    end

    // Auto-repeat state machine: a release acceptance always wins and
    // suppresses any repeat pulse that would have coincided with it.
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      repeat_d  = 1'b0;
      if (fall) begin
        state_d   = ST_IDLE;
        rpt_cnt_d = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise && REPEAT_EN) begin
              state_d   = ST_DELAY;
              rpt_cnt_d = RCW'(1);
            end
          end
          ST_DELAY: begin
            if (rpt_cnt_q == RD_VAL) begin
              repeat_d  = 1'b1;
              state_d   = ST_REPEAT;
              rpt_cnt_d = RCW'(1);
            end else begin
              rpt_cnt_d = rpt_cnt_q + RCW'(1);
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt_q == RP_VAL) begin
              repeat_d  = 1'b1;
              rpt_cnt_d = RCW'(1);
            end else begin
              rpt_cnt_d = rpt_cnt_q + RCW'(1);
            end
          end
          default: begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
          end
        endcase
      end
    end

    // State registers with synchronous reset; synchroniser resets to released.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of ordering.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q   <= 1'b1;
        sync2_q   <= 1'b1;
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        state_q   <= ST_IDLE;
        rpt_cnt_q <= '0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed test of key_debouncer with short debounce and
// repeat intervals. Inputs change 2 time units after a rising edge and
// outputs are sampled at the same point, so "after edge k" means the value
// registered on the k-th edge following the edge where the stimulus changed.

module tb_key_debouncer;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_repeat;

  int checks = 0;
  int errors = 0;

  key_debouncer #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all(input string tag, input logic [NK-1:0] lv, input logic [NK-1:0] pr,
                           input logic [NK-1:0] rl, input logic [NK-1:0] rp);
    check({tag, "_level"},   key_level,   lv);
    check({tag, "_press"},   key_press,   pr);
    check({tag, "_release"}, key_release, rl);
    check({tag, "_repeat"},  key_repeat,  rp);
  endtask

  // Presses the keys in mask after the current edge (edge 0), releases them
  // after edge 'hold', and checks every output against the timing model:
  // acceptance DB+2 edges after a change, first repeat RD edges after the
  // press, then every RP edges, and no repeat from the release edge on.
  task automatic run_hold(input string tag, input logic [NK-1:0] mask, input int hold, input int total);
    int pk, rk;
    logic [NK-1:0] lv, pr, rl, rp;
    pk = DB + 2;
    rk = hold + DB + 2;
    key_n = key_n & ~mask;
    for (int k = 1; k <= total; k++) begin
      step();
      lv = (k >= pk && k < rk) ? mask : '0;
      pr = (k == pk) ? mask : '0;
      rl = (k == rk) ? mask : '0;
      rp = (k >= pk + RD && k < rk && ((k - pk - RD) % RP) == 0) ? mask : '0;
      check_all($sformatf("%s_k%0d", tag, k), lv, pr, rl, rp);
      if (k == hold) key_n = key_n | mask;
    end
  endtask

  initial begin
    // 1: reset for 3 cycles with all keys released, then 20 quiet cycles.
    reset = 1'b1;
    key_n = 4'b1111;
    step();
    check_all("t1_in_reset", '0, '0, '0, '0);
    step();
    step();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check_all($sformatf("t1_idle_k%0d", k), '0, '0, '0, '0);
    end

    // 2: clean press of key 0; accepted on edge 6, press pulse lasts one cycle.
    key_n[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("t2_level_k%0d", k), key_level, (k >= 6) ? 4'b0001 : 4'b0000);
      check($sformatf("t2_press_k%0d", k), key_press, (k == 6) ? 4'b0001 : 4'b0000);
    end

    // 3: five 3-cycle release bounces must not change the level.
    for (int b = 0; b < 5; b++) begin
      key_n[0] = 1'b1;
      for (int s = 0; s < 6; s++) begin
        step();
        check($sformatf("t3_bounce%0d_level_s%0d", b, s), key_level, 4'b0001);
        check($sformatf("t3_bounce%0d_rel_s%0d", b, s), key_release, 4'b0000);
        if (s == 2) key_n[0] = 1'b0;
      end
    end
    step();
    // Clean release: release pulse on the 6th edge, no repeat from then on.
    key_n[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("t3_rel_level_k%0d", k), key_level, (k < 6) ? 4'b0001 : 4'b0000);
      check($sformatf("t3_rel_pulse_k%0d", k), key_release, (k == 6) ? 4'b0001 : 4'b0000);
      if (k >= 6) check($sformatf("t3_rel_norpt_k%0d", k), key_repeat, 4'b0000);
    end

    // 4: key 2 held 40 cycles; its release coincides with a would-be repeat.
    run_hold("t4", 4'b0100, 40, 52);

    // 5: keys 1 and 3 pressed together; pulses and repeats coincide.
    run_hold("t5", 4'b1010, 20, 30);

    // 6: key 0 held into the repeat phase, then a 1-cycle reset.
    key_n[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 16 || k == 19) check($sformatf("t6_pre_rpt_k%0d", k), key_repeat, 4'b0001);
      if (k == 20) check("t6_pre_level", key_level, 4'b0001);
    end
    reset = 1'b1;
    step();
    check_all("t6_reset", '0, '0, '0, '0);
    reset = 1'b0;
    run_hold("t6", 4'b0001, 22, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
